// File: rtl/sz_frame_ctrl.sv
// sz_frame_ctrl: per-frame row sequencer gating an upstream row buffer into a datapath (start/abort in, s_* upstream, dp_* datapath, busy/done/row_idx/cnt*/err status)
module sz_frame_ctrl #(
  parameter int XDIM     = 128,
  parameter int ROWS     = 1000,
  parameter int DRAIN    = 512,
  parameter int IN_WIDTH = 32,
  parameter int CW       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                s_row_avail,
  input  logic [IN_WIDTH-1:0] s_data,
  output logic                s_ready,
  output logic                dp_clr,
  output logic                dp_enable,
  output logic [IN_WIDTH-1:0] dp_data,
  input  logic                dp_v1,
  input  logic                dp_v2,
  input  logic                dp_v3,
  output logic                busy,
  output logic                done,
  output logic [15:0]         row_idx,
  output logic [CW-1:0]       cnt1,
  output logic [CW-1:0]       cnt2,
  output logic [CW-1:0]       cnt3,
  output logic                err
);
  localparam int XW = XDIM > 1 ? $clog2(XDIM) : 1;
  localparam int DW = DRAIN > 1 ? $clog2(DRAIN) : 1;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_WAIT_ROW, ST_STREAM, ST_DRAIN, ST_DONE} state_t;
  state_t        state_q, state_d;
  logic [XW-1:0] col_q, col_d;
  logic [DW-1:0] drn_q, drn_d;
  logic [15:0]   row_q, row_d;
  logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, cnt3_q, cnt3_d;
  logic          err_q, err_d, clr_q, clr_d;
  logic          last_col, last_row, drain_end, clr, counting;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      drn_q   <= '0;
      row_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      cnt3_q  <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      drn_q   <= drn_d;
      row_q   <= row_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      cnt3_q  <= cnt3_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
    end
  end
  always_comb begin
    last_col  = col_q == XW'(XDIM - 1);
    last_row  = row_q == 16'(ROWS - 1);
    drain_end = drn_q == DW'(DRAIN - 1);
    state_d   = state_q;
    if (state_q != ST_IDLE && abort) state_d = ST_IDLE;
    else
      case (state_q)
        ST_IDLE:     state_d = start ? ST_CLEAR : ST_IDLE;
        ST_CLEAR:    state_d = ST_WAIT_ROW;
        ST_WAIT_ROW: state_d = s_row_avail ? ST_STREAM : ST_WAIT_ROW;
        ST_STREAM:   state_d = !last_col ? ST_STREAM : last_row ? ST_DRAIN : ST_WAIT_ROW;
        ST_DRAIN:    state_d = drain_end ? ST_DONE : ST_DRAIN;
        ST_DONE:     state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    clr      = state_q == ST_IDLE && state_d == ST_CLEAR;
    counting = state_q == ST_WAIT_ROW || state_q == ST_STREAM || state_q == ST_DRAIN;
    col_d    = state_q == ST_STREAM && !last_col ? col_q + XW'(1) : '0;
    drn_d    = state_q == ST_DRAIN ? drn_q + DW'(1) : '0;
    row_d    = clr ? '0 : state_q == ST_STREAM && state_d == ST_WAIT_ROW ? row_q + 16'd1 : row_q;
    cnt1_d   = clr ? '0 : counting && dp_v1 && !(&cnt1_q) ? cnt1_q + CW'(1) : cnt1_q;
    cnt2_d   = clr ? '0 : counting && dp_v2 && !(&cnt2_q) ? cnt2_q + CW'(1) : cnt2_q;
    cnt3_d   = clr ? '0 : counting && dp_v3 && !(&cnt3_q) ? cnt3_q + CW'(1) : cnt3_q;
    err_d    = clr ? 1'b0 : err_q | (dp_v2 & dp_v3);
    clr_d    = clr | (state_q != ST_IDLE && abort);
  end
  always_comb begin
    dp_enable = state_q == ST_STREAM;
    s_ready   = dp_enable;
    dp_data   = dp_enable ? s_data : '0;
    busy      = state_q != ST_IDLE;
    done      = state_q == ST_DONE;
    dp_clr    = clr_q;
    row_idx   = row_q;
    cnt1      = cnt1_q;
    cnt2      = cnt2_q;
    cnt3      = cnt3_q;
    err       = err_q;
  end
endmodule

// File: tb/tb_sz_frame_ctrl.sv
// tb_sz_frame_ctrl: directed table-driven and sequence checks of sz_frame_ctrl at XDIM=4 ROWS=4 DRAIN=6, with a CW=2 twin for saturation
module tb_sz_frame_ctrl;
  localparam int IW = 8;
  typedef struct {
    logic          start, v1, v2;
    logic [IW-1:0] data;
    logic          busy, clr, en, done;
    logic [15:0]   row;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, abort = 0, s_row_avail = 1, dp_v1 = 0, dp_v2 = 0, dp_v3 = 0;
  logic [IW-1:0] s_data = '0;
  logic s_ready, dp_clr, dp_enable, busy, done, err;
  logic [IW-1:0] dp_data;
  logic [15:0] row_idx;
  logic [31:0] cnt1, cnt2, cnt3;
  logic t_ready, t_clr, t_en, t_busy, t_done, t_err;
  logic [IW-1:0] t_data;
  logic [15:0] t_row;
  logic [1:0] t_cnt1, t_cnt2, t_cnt3;
  int n_cmp = 0, n_err = 0;
  vec_t tv[30];
  sz_frame_ctrl #(.XDIM(4), .ROWS(4), .DRAIN(6), .IN_WIDTH(IW), .CW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_row_avail(s_row_avail), .s_data(s_data),
    .s_ready(s_ready), .dp_clr(dp_clr), .dp_enable(dp_enable), .dp_data(dp_data),
    .dp_v1(dp_v1), .dp_v2(dp_v2), .dp_v3(dp_v3), .busy(busy), .done(done), .row_idx(row_idx),
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .err(err));
  sz_frame_ctrl #(.XDIM(4), .ROWS(4), .DRAIN(6), .IN_WIDTH(IW), .CW(2)) sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_row_avail(s_row_avail), .s_data(s_data),
    .s_ready(t_ready), .dp_clr(t_clr), .dp_enable(t_en), .dp_data(t_data),
    .dp_v1(dp_v1), .dp_v2(dp_v2), .dp_v3(dp_v3), .busy(t_busy), .done(t_done), .row_idx(t_row),
    .cnt1(t_cnt1), .cnt2(t_cnt2), .cnt3(t_cnt3), .err(t_err));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    start = 0; abort = 0; dp_v1 = 0; dp_v2 = 0; dp_v3 = 0; s_row_avail = 1; rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int first, gap, nen, ndone, nbusy;
    for (int c = 0; c < 30; c++) begin
      tv[c].start = c == 0;
      tv[c].v1    = c == 2 || c == 5 || c == 12 || c == 22 || c == 27;
      tv[c].v2    = c == 4 || c == 9 || c == 25;
      tv[c].data  = IW'(c * 7 + 3);
      tv[c].en    = (c >= 3 && c <= 6) || (c >= 8 && c <= 11) || (c >= 13 && c <= 16) || (c >= 18 && c <= 21);
      tv[c].busy  = c >= 1 && c <= 28;
      tv[c].clr   = c == 1;
      tv[c].done  = c == 28;
      tv[c].row   = c <= 6 ? 16'd0 : c <= 11 ? 16'd1 : c <= 16 ? 16'd2 : 16'd3;
    end
    rst = 1;
    step;
    step;
    #1;
    chk("reset outs", {busy, dp_clr, dp_enable, s_ready, done, err, row_idx, dp_data}, {6'b010000, 16'd0, 8'd0});
    chk("reset cnts", {cnt1, cnt2, cnt3[15:0]}, 80'd0);
    idle_in;
    step;
    chk("reset clr drop", {dp_clr, busy}, 2'b00);
    for (int c = 0; c < 30; c++) begin
      idle_in;
      start = tv[c].start; dp_v1 = tv[c].v1; dp_v2 = tv[c].v2; s_data = tv[c].data;
      #1;
      chk($sformatf("frame c%0d", c), {busy, dp_clr, dp_enable, s_ready, done, row_idx, dp_data},
          {tv[c].busy, tv[c].clr, tv[c].en, tv[c].en, tv[c].done, tv[c].row, (tv[c].en ? tv[c].data : 8'h0)});
      step;
    end
    idle_in;
    #1;
    chk("stats cnt1", cnt1, 5);
    chk("stats cnt2", cnt2, 3);
    chk("stats cnt3/err", {cnt3, err}, 0);
    chk("stats hold row", row_idx, 3);
    chk("sat cnt1/cnt2", {t_cnt1, t_cnt2}, 4'b1111);
    step;
    first = -1; gap = 0; nen = 0; ndone = -1;
    for (int c = 0; c < 46; c++) begin
      idle_in;
      start = c == 0;
      s_row_avail = !(c >= 12 && c < 22);
      #1;
      if (dp_enable && row_idx == 2 && first < 0) first = c;
      if (c >= 12 && c <= 22 && s_ready) gap++;
      if (dp_enable) nen++;
      if (done && ndone < 0) ndone = c;
      step;
    end
    chk("gate row2 start", 64'(first), 64'(23));
    chk("gate no ready", 64'(gap), 0);
    chk("gate enables", 64'(nen), 16);
    chk("gate done cycle", 64'(ndone), 64'(38));
    ndone = 0;
    for (int c = 0; c < 33; c++) begin
      idle_in;
      start = c == 0 || c == 21;
      abort = c == 10 || c == 26 || c == 30;
      #1;
      if (done) ndone++;
      if (c == 10) chk("abort at col2", {dp_enable, row_idx}, {1'b1, 16'd1});
      if (c == 11) chk("abort next", {busy, dp_clr, dp_enable}, 3'b010);
      if (c == 12) chk("abort clr one", {busy, dp_clr}, 2'b00);
      if (c == 22) chk("restart clear", {busy, dp_clr, row_idx}, {2'b11, 16'd0});
      if (c == 25) chk("restart row0", {dp_enable, row_idx}, {1'b1, 16'd0});
      if (c == 27) chk("abort2 next", {busy, dp_clr}, 2'b01);
      if (c == 31) chk("abort in idle", {busy, dp_clr}, 2'b00);
      step;
    end
    chk("abort no done", 64'(ndone), 0);
    for (int c = 0; c < 33; c++) begin
      idle_in;
      start = c == 0 || c == 5 || c == 15 || c == 22 || c == 29;
      dp_v2 = c == 5;
      dp_v3 = c == 3 || c == 5 || c == 8 || c == 13 || c == 20 || c == 24;
      abort = c == 31;
      #1;
      if (c == 5) chk("err before", err, 0);
      if (c == 6) chk("err set", err, 1);
      if (c == 28) chk("err done", {done, err}, 2'b11);
      if (c == 29) chk("err after", {busy, err, cnt2[7:0], cnt3[7:0]}, {2'b01, 8'd1, 8'd6});
      if (c == 29) chk("sat cnt3", t_cnt3, 2'b11);
      if (c == 30) chk("err cleared", {busy, dp_clr, err, cnt3[7:0]}, {3'b110, 8'd0});
      step;
    end
    ndone = 0; nbusy = 0;
    for (int c = 0; c < 36; c++) begin
      idle_in;
      start = c == 0 || c == 24;
      abort = c == 24;
      rst = c == 24;
      dp_v1 = c == 3;
      dp_v2 = c == 4;
      dp_v3 = c == 4;
      s_data = 8'hA5;
      #1;
      if (c == 20) chk("pre-rst", {busy, err, cnt1[7:0], row_idx}, {2'b11, 8'd1, 16'd3});
      if (c == 25) chk("rst in drain", {busy, dp_clr, s_ready, dp_enable, done, err, row_idx, dp_data}, {6'b010000, 16'd0, 8'd0});
      if (c == 25) chk("rst cnts", {cnt1, cnt2}, 0);
      if (c >= 25 && done) ndone++;
      if (c >= 26 && busy) nbusy++;
      step;
    end
    chk("rst no done", 64'(ndone), 0);
    chk("rst stays idle", 64'(nbusy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sz_frame_ctrl.md
SZ_FRAME_CTRL -- requirements
Module: sz_frame_ctrl

Interface
REQ-001 SHALL have parameter XDIM, default 128: points per row, and the number of dp_enable cycles per row.
REQ-002 SHALL have parameter ROWS, default 1000: rows per frame, legal range 4..65535.
REQ-003 SHALL have parameter DRAIN, default 512: cycles spent waiting for the datapath to flush after the last row.
REQ-004 SHALL have parameter IN_WIDTH, default 32: width of a data word.
REQ-005 SHALL have parameter CW, default 32: width of each statistics counter.
REQ-006 SHALL have ports as follows; reset rst is synchronous and active-high, and the clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame start pulse; honoured only in IDLE
- abort  in  1  terminate the frame; honoured in any non-IDLE state
- s_row_avail  in  1  upstream holds at least XDIM buffered words
- s_data  in  IN_WIDTH  upstream word
- s_ready  out  1  word consumed this cycle
- dp_clr  out  1  registered clear pulse to the datapath reset
- dp_enable  out  1  datapath enable
- dp_data  out  IN_WIDTH  datapath input word
- dp_v1  in  1  datapath fit-valid
- dp_v2  in  1  datapath quant-valid
- dp_v3  in  1  datapath raw-valid
- busy  out  1  state is not IDLE
- done  out  1  one-cycle end-of-frame pulse
- row_idx  out  16  index of the current row
- cnt1, cnt2, cnt3  out  CW each  per-frame counts of dp_v1, dp_v2, dp_v3
- err  out  1  sticky protocol error

Function
REQ-007 SHALL implement states IDLE, CLEAR, WAIT_ROW, STREAM, DRAIN and DONE, with every state held in registers.
REQ-008 SHALL transition IDLE->CLEAR on start; start SHALL be ignored in every other state.
REQ-009 SHALL spend exactly one cycle in CLEAR with dp_clr=1, zero cnt1/cnt2/cnt3, err, row_idx and the column counter, and then go to WAIT_ROW.
REQ-010 SHALL, in WAIT_ROW, hold s_ready=0 and dp_enable=0, and go to STREAM in the cycle after s_row_avail is sampled high.
REQ-011 SHALL, in STREAM, drive s_ready=1 and dp_enable=1, with dp_data equal to s_data combinationally.
- STREAM SHALL last exactly XDIM consecutive cycles; it is never stalled and never ends mid-row.
- s_row_avail SHALL be ignored while in STREAM.
REQ-012 SHALL count columns 0..XDIM-1 in STREAM.
- On column XDIM-1, if row_idx is ROWS-1, SHALL go to DRAIN.
- Otherwise SHALL increment row_idx and go to WAIT_ROW.
REQ-013 SHALL drive dp_data to 0 whenever dp_enable=0.
REQ-014 SHALL remain in DRAIN for exactly DRAIN cycles with dp_enable=0 and s_ready=0, then go to DONE.
REQ-015 SHALL assert done for the single DONE cycle, then return to IDLE.
- After done, row_idx and the statistics counters SHALL hold their values until the next CLEAR.
REQ-016 SHALL increment cnt1, cnt2 or cnt3 when the matching dp_v* is high in WAIT_ROW, STREAM or DRAIN.
- Each counter SHALL saturate at all-ones and SHALL NOT wrap.
REQ-017 SHALL set err when dp_v2 and dp_v3 are high in the same cycle; err SHALL clear only in CLEAR or on rst.
REQ-018 SHALL, when abort is sampled in any non-IDLE state, enter IDLE next cycle with dp_clr=1 for that one cycle and done=0.
- abort SHALL take priority over every other transition, including the STREAM end-of-row and DRAIN-end transitions.
- abort SHALL be ignored in IDLE.
REQ-019 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-020 SHALL, on rst, enter IDLE and set s_ready=0, dp_enable=0, dp_data=0, done=0, err=0 and row_idx=0, with all counters at 0.
- dp_clr SHALL be 1 in the cycle after rst is sampled.
REQ-021 SHALL give rst priority over start and abort; rst mid-frame SHALL discard the frame without pulsing done.

Verification (XDIM=4, ROWS=4, DRAIN=6)
REQ-022 SHALL verify the full-frame sequence: s_row_avail=1 constantly, start at cycle 0.
- CLEAR at cycle 1, dp_enable high in cycles 3-6, 8-11, 13-16 and 18-21 (16 enables in total).
- DRAIN in cycles 22-27, done at cycle 28, busy=0 at cycle 29.
REQ-023 SHALL verify row gating: s_row_avail low for 10 cycles before row 2 -> STREAM is delayed by exactly 10 cycles and no s_ready is seen during the gap.
REQ-024 SHALL verify statistics and saturation.
- dp_v1 pulsed 5 times and dp_v2 3 times during the frame -> cnt1=5, cnt2=3, cnt3=0 after done.
- With CW=2 and 6 dp_v3 pulses -> cnt3=3.
REQ-025 SHALL verify abort: abort on column 2 of row 1 -> IDLE next cycle, dp_clr=1 for one cycle, done never asserted, and a new start then begins at row_idx=0.
REQ-026 SHALL verify the error flag: dp_v2=dp_v3=1 for one cycle -> err=1 and held through done; the next start -> err=0 in CLEAR.
REQ-027 SHALL verify reset behaviour: rst asserted in DRAIN -> IDLE with all outputs at their reset values; start while busy -> no effect on the state sequence.
